cart_download: RTL and testbench

CART_DOWNLOAD -- requirements
Module: cart_download

---
 rtl/cart_download.sv | 177 +++++++++++++++++
 tb/tb_cart_download.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_download.sv
// cart_download: packs 16-bit ioctl halfwords from a cartridge download into
// 32-bit SDRAM writes. The byte order (z64/v64/n64) is detected from the
// header word, and the bytes of every word are reordered to z64 order.
module cart_download #(
    parameter logic [26:0] CART_START = 27'h0800000
) (
    input  logic        clk1x,
    input  logic        reset_n,
    input  logic        dl_active,
    input  logic        ioctl_wr,
    input  logic [26:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    output logic        ioctl_wait,
    output logic        mem_req,
    output logic [26:0] mem_addr,
    output logic [31:0] mem_data,
    input  logic        mem_ready,
    output logic [1:0]  rom_format,
    output logic        cart_loaded,
    output logic [26:0] rom_size,
    output logic        dl_error
);

    typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_BUSY, S_FLUSH} state_t;
    typedef enum logic [1:0] {FMT_Z64, FMT_V64, FMT_N64, FMT_UNKNOWN} fmt_t;

    state_t      state;
    fmt_t        fmt_q;
    logic        dl_active_q;
    logic [7:0]  b0_q;
    logic [7:0]  b1_q;
    logic [24:0] waddr_q;

    logic [7:0]  b2_in;
    logic [7:0]  b3_in;
    fmt_t        hdr_fmt;
    fmt_t        word_fmt;
    logic [31:0] word_data;
    logic [26:0] word_addr;
    logic [26:0] hw_end;
    logic [26:0] size_max;
    logic        accept_lo;
    logic        accept_hi;
    logic        issue;

    assign rom_format = fmt_q;

    function automatic fmt_t detect(input logic [7:0] b0, input logic [7:0] b1,
                                    input logic [7:0] b2, input logic [7:0] b3);
        case ({b0, b1, b2, b3})
            32'h80371240: detect = FMT_Z64;
            32'h37804012: detect = FMT_V64;
            32'h40123780: detect = FMT_N64;
            default:      detect = FMT_UNKNOWN;
        endcase
    endfunction

    function automatic logic [31:0] pack(input fmt_t f, input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3);
        case (f)
            FMT_V64: pack = {b2, b3, b0, b1};
            FMT_N64: pack = {b0, b1, b2, b3};
            default: pack = {b3, b2, b1, b0};
        endcase
    endfunction

    // Assemble the outgoing word; FLUSH pads the missing upper halfword with zeros.
    // Word 0 uses the freshly detected format so it is written in the same order as the rest.
    always_comb begin
        b2_in     = (state == S_FLUSH) ? '0 : ioctl_dout[7:0];
        b3_in     = (state == S_FLUSH) ? '0 : ioctl_dout[15:8];
        hdr_fmt   = detect(b0_q, b1_q, b2_in, b3_in);
        word_fmt  = (waddr_q == '0) ? hdr_fmt : fmt_q;
        word_data = pack(word_fmt, b0_q, b1_q, b2_in, b3_in);
        word_addr = CART_START + {waddr_q, 2'b00};
        hw_end    = ioctl_addr + 27'd2;
        size_max  = (hw_end > rom_size) ? hw_end : rom_size;
        accept_lo = (state == S_LO) && ioctl_wr && !ioctl_addr[1];
        accept_hi = (state == S_HI) && ioctl_wr && ioctl_addr[1];
        issue     = accept_hi || (state == S_FLUSH);
    end

    // Download state machine with registered handshake and status outputs.
    always_ff @(posedge clk1x or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            fmt_q       <= FMT_Z64;
            dl_active_q <= 1'b0;
            b0_q        <= '0;
            b1_q        <= '0;
            waddr_q     <= '0;
            ioctl_wait  <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            mem_data    <= '0;
            cart_loaded <= 1'b0;
            rom_size    <= '0;
            dl_error    <= 1'b0;
        end else begin
            dl_active_q <= dl_active;
            mem_req     <= 1'b0;

            if (accept_lo || accept_hi)
                rom_size <= size_max;

            case (state)
                S_IDLE: begin
                    if (dl_active && !dl_active_q) begin
                        fmt_q       <= FMT_Z64;
                        rom_size    <= '0;
                        dl_error    <= 1'b0;
                        cart_loaded <= 1'b0;
                        state       <= S_LO;
                    end
                end
                S_LO: begin
                    // A halfword arriving with the end of the window is taken first.
                    if (accept_lo) begin
                        b0_q    <= ioctl_dout[7:0];
                        b1_q    <= ioctl_dout[15:8];
                        waddr_q <= ioctl_addr[26:2];
                        state   <= dl_active ? S_HI : S_FLUSH;
                    end else begin
                        if (ioctl_wr)
                            dl_error <= 1'b1;
                        if (!dl_active) begin
                            cart_loaded <= 1'b1;
                            state       <= S_IDLE;
                        end
                    end
                end
                S_HI: begin
                    if (accept_hi) begin
                        state <= S_BUSY;
                    end else begin
                        if (ioctl_wr)
                            dl_error <= 1'b1;
                        if (!dl_active)
                            state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (ioctl_wr)
                        dl_error <= 1'b1;
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    if (ioctl_wr)
                        dl_error <= 1'b1;
                    if (mem_ready) begin
                        ioctl_wait <= 1'b0;
                        if (dl_active) begin
                            state <= S_LO;
                        end else begin
                            cart_loaded <= 1'b1;
                            state       <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (issue) begin
                mem_req    <= 1'b1;
                ioctl_wait <= 1'b1;
                mem_addr   <= word_addr;
                mem_data   <= word_data;
                if (waddr_q == '0) begin
                    fmt_q <= hdr_fmt;
                    if (hdr_fmt == FMT_UNKNOWN)
                        dl_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cart_download.sv
// Directed bench for cart_download: header formats, odd-length flush,
// overrun, halfword mismatch and reset during a pending write.
module tb_cart_download;

    logic        clk1x = 1'b0;
    logic        reset_n;
    logic        dl_active;
    logic        ioctl_wr;
    logic [26:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic        ioctl_wait;
    logic        mem_req;
    logic [26:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [1:0]  rom_format;
    logic        cart_loaded;
    logic [26:0] rom_size;
    logic        dl_error;

    int vectors = 0;
    int miscompares = 0;

    cart_download #(.CART_START(27'h0800000)) dut (
        .clk1x      (clk1x),
        .reset_n    (reset_n),
        .dl_active  (dl_active),
        .ioctl_wr   (ioctl_wr),
        .ioctl_addr (ioctl_addr),
        .ioctl_dout (ioctl_dout),
        .ioctl_wait (ioctl_wait),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .rom_format (rom_format),
        .cart_loaded(cart_loaded),
        .rom_size   (rom_size),
        .dl_error   (dl_error)
    );

    always #5 clk1x = ~clk1x;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1x);
        #1;
    endtask

    task automatic write_hw(input logic [26:0] a, input logic [15:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic start_dl();
        dl_active = 1'b1;
        tick();
    endtask

    // Waits (bounded) for mem_req, checks the word, holds it for `delay` cycles, then completes.
    task automatic handshake(input string tag, input int delay,
                             input logic [26:0] exp_addr, input logic [31:0] exp_data);
        int k = 0;
        int n_wait = 0;
        int n_req = 0;
        while (!mem_req && k < 8) begin
            tick();
            k++;
        end
        chk({tag, "_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
        chk({tag, "_data"}, mem_data, exp_data);
        for (int i = 0; i < delay; i++) begin
            if (ioctl_wait) n_wait++;
            if (mem_req) n_req++;
            tick();
        end
        if (ioctl_wait) n_wait++;
        if (mem_req) n_req++;
        chk({tag, "_addr_hold"}, 32'(mem_addr), 32'(exp_addr));
        chk({tag, "_data_hold"}, mem_data, exp_data);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk({tag, "_wait_low"}, 32'(ioctl_wait), 32'd0);
        chk({tag, "_wait_cycles"}, 32'(n_wait), 32'(delay + 1));
        chk({tag, "_req_pulses"}, 32'(n_req), 32'd1);
    endtask

    initial begin
        reset_n    = 1'b0;
        dl_active  = 1'b0;
        ioctl_wr   = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        mem_ready  = 1'b0;
        #1;
        chk("rst_wait", 32'(ioctl_wait), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_data", mem_data, 32'd0);
        chk("rst_fmt", 32'(rom_format), 32'd0);
        chk("rst_size", 32'(rom_size), 32'd0);
        chk("rst_loaded", 32'(cart_loaded), 32'd0);
        chk("rst_err", 32'(dl_error), 32'd0);
        tick();
        tick();
        @(negedge clk1x);
        reset_n = 1'b1;
        tick();

        // z64 header plus one further word
        start_dl();
        write_hw(27'd0, 16'h3780);
        write_hw(27'd2, 16'h4012);
        chk("z64_fmt", 32'(rom_format), 32'd0);
        chk("z64_err", 32'(dl_error), 32'd0);
        handshake("z64_w0", 3, 27'h0800000, 32'h40123780);
        write_hw(27'd4, 16'hBBAA);
        write_hw(27'd6, 16'hDDCC);
        handshake("z64_w1", 1, 27'h0800004, 32'hDDCCBBAA);
        chk("z64_size", 32'(rom_size), 32'd8);
        dl_active = 1'b0;
        tick();
        chk("z64_loaded", 32'(cart_loaded), 32'd1);
        chk("z64_err_end", 32'(dl_error), 32'd0);

        // v64 header, following word swapped the same way
        start_dl();
        chk("v64_loaded_clr", 32'(cart_loaded), 32'd0);
        chk("v64_size_clr", 32'(rom_size), 32'd0);
        write_hw(27'd0, 16'h8037);
        write_hw(27'd2, 16'h1240);
        chk("v64_fmt", 32'(rom_format), 32'd1);
        handshake("v64_w0", 2, 27'h0800000, 32'h40123780);
        write_hw(27'd4, 16'h2211);
        write_hw(27'd6, 16'h4433);
        handshake("v64_w1", 2, 27'h0800004, 32'h33441122);
        dl_active = 1'b0;
        tick();
        chk("v64_loaded", 32'(cart_loaded), 32'd1);

        // n64 header, then a halfword in the wrong slot
        start_dl();
        chk("n64_fmt_clr", 32'(rom_format), 32'd0);
        write_hw(27'd0, 16'h1240);
        write_hw(27'd2, 16'h8037);
        chk("n64_fmt", 32'(rom_format), 32'd2);
        chk("n64_err", 32'(dl_error), 32'd0);
        handshake("n64_w0", 1, 27'h0800000, 32'h40123780);
        write_hw(27'd4, 16'h2211);
        write_hw(27'd6, 16'h4433);
        handshake("n64_w1", 1, 27'h0800004, 32'h11223344);
        write_hw(27'd10, 16'h7777);
        chk("mis_err", 32'(dl_error), 32'd1);
        chk("mis_req", 32'(mem_req), 32'd0);
        chk("mis_size", 32'(rom_size), 32'd8);
        dl_active = 1'b0;
        tick();
        chk("n64_loaded", 32'(cart_loaded), 32'd1);

        // unknown header: z64 byte order, error flagged
        start_dl();
        chk("unk_err_clr", 32'(dl_error), 32'd0);
        write_hw(27'd0, 16'hAAAA);
        write_hw(27'd2, 16'hBBBB);
        chk("unk_fmt", 32'(rom_format), 32'd3);
        chk("unk_err", 32'(dl_error), 32'd1);
        handshake("unk_w0", 1, 27'h0800000, 32'hBBBBAAAA);
        dl_active = 1'b0;
        tick();

        // overrun during BUSY, then an odd-length tail flushed on window end
        start_dl();
        write_hw(27'd0, 16'h3780);
        write_hw(27'd2, 16'h4012);
        chk("ovr_req", 32'(mem_req), 32'd1);
        write_hw(27'd4, 16'hFFFF);
        chk("ovr_err", 32'(dl_error), 32'd1);
        chk("ovr_no_req", 32'(mem_req), 32'd0);
        chk("ovr_wait", 32'(ioctl_wait), 32'd1);
        chk("ovr_size", 32'(rom_size), 32'd4);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("ovr_wait_low", 32'(ioctl_wait), 32'd0);
        write_hw(27'd4, 16'h5566);
        dl_active = 1'b0;
        handshake("odd_flush", 2, 27'h0800004, 32'h00005566);
        chk("odd_loaded", 32'(cart_loaded), 32'd1);
        chk("odd_size", 32'(rom_size), 32'd6);
        chk("odd_err", 32'(dl_error), 32'd1);

        // reset pulse while a write is pending
        start_dl();
        write_hw(27'd0, 16'h3780);
        write_hw(27'd2, 16'h4012);
        chk("rb_req", 32'(mem_req), 32'd1);
        tick();
        dl_active = 1'b0;
        reset_n   = 1'b0;
        #1;
        chk("rb_wait", 32'(ioctl_wait), 32'd0);
        chk("rb_addr", 32'(mem_addr), 32'd0);
        chk("rb_data", mem_data, 32'd0);
        chk("rb_size", 32'(rom_size), 32'd0);
        chk("rb_err", 32'(dl_error), 32'd0);
        @(negedge clk1x);
        reset_n = 1'b1;
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("rb_late_req", 32'(mem_req), 32'd0);
        chk("rb_late_wait", 32'(ioctl_wait), 32'd0);
        tick();
        chk("rb_late_req2", 32'(mem_req), 32'd0);
        start_dl();
        write_hw(27'd0, 16'h1240);
        write_hw(27'd2, 16'h8037);
        chk("rb_new_fmt", 32'(rom_format), 32'd2);
        handshake("rb_new_w0", 1, 27'h0800000, 32'h40123780);
        dl_active = 1'b0;
        tick();
        chk("rb_new_loaded", 32'(cart_loaded), 32'd1);
        chk("rb_new_size", 32'(rom_size), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
